// File: rtl/line_pkg.sv
// Shared types and constants for the line-following controller:
// FSM states, turn command codes, motor direction codes and duty saturation.
package line_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FOLLOW = 3'd1,
      NODE   = 3'd2,
      TURN   = 3'd3,
      LOST   = 3'd4
   } state_t;

   localparam logic [1:0] TC_STR   = 2'd0;
   localparam logic [1:0] TC_RIGHT = 2'd1;
   localparam logic [1:0] TC_UTURN = 2'd2;
   localparam logic [1:0] TC_LEFT  = 2'd3;

   // Direction pairs are {a, b}.
   localparam logic [1:0] FWD = 2'b10;
   localparam logic [1:0] REV = 2'b01;
   localparam logic [1:0] OFF = 2'b00;

   function automatic int sat_duty(input int val, input int max_val);
      if (val < 0) return 0;
      else if (val > max_val) return max_val;
      else return val;
   endfunction

endpackage

// File: rtl/lfa_classifier.sv
// Hysteresis black/white classification of every LFA channel (registered)
// and the signed position error derived from the registered classes.
module lfa_classifier
   import line_pkg::*;
#(
   parameter int NUM_SENS = 3,
   parameter int ADC_W    = 12,
   parameter int TH_HI    = 1000,
   parameter int TH_LO    = 250,
   parameter int ERR_W    = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_SENS*ADC_W-1:0]     sens,
   output logic [NUM_SENS-1:0]           cls,
   output logic signed [ERR_W-1:0]       err
);

   localparam int MID = (NUM_SENS - 1) / 2;

   logic [NUM_SENS-1:0] cls_d, cls_q;

   // Samples inside the grey band keep the previous class.
   always_comb begin
      cls_d = cls_q;
      for (int i = 0; i < NUM_SENS; i++) begin
         if (int'(sens[i*ADC_W +: ADC_W]) > TH_HI)
            cls_d[i] = 1'b1;
         else if (int'(sens[i*ADC_W +: ADC_W]) < TH_LO)
            cls_d[i] = 1'b0;
      end
   end

   always_comb begin
      err = '0;
      for (int i = 0; i < NUM_SENS; i++) begin
         if (cls_q[i])
            err = err + ERR_W'(i - MID);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         cls_q <= '0;
      else
         cls_q <= cls_d;
   end

   assign cls = cls_q;

endmodule

// File: rtl/line_follow_ctrl.sv
// Line-following controller: proportional steering, debounced node detection,
// handshaked turn execution, lost-line recovery and a wrapping node counter.
module line_follow_ctrl
   import line_pkg::*;
#(
   parameter int NUM_SENS  = 3,
   parameter int ADC_W     = 12,
   parameter int TH_HI     = 1000,
   parameter int TH_LO     = 250,
   parameter int DUTY_W    = 5,
   parameter int BASE_DUTY = 16,
   parameter int STEER_K   = 4,
   parameter int TURN_DUTY = 20,
   parameter int NODE_DEB  = 4,
   parameter int TURN_MIN  = 1024,
   parameter int LOST_TO   = 65535
) (
   input  logic                      clk_3125KHz,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      stop,
   input  logic [NUM_SENS*ADC_W-1:0] sens,
   input  logic [1:0]                turn_cmd,
   input  logic                      turn_valid,
   output logic                      turn_ready,
   output logic                      m1_a,
   output logic                      m1_b,
   output logic                      m2_a,
   output logic                      m2_b,
   output logic [DUTY_W-1:0]         dc1,
   output logic [DUTY_W-1:0]         dc2,
   output logic                      node_flag,
   output logic                      node_pulse,
   output logic [7:0]                node_count,
   output logic                      lost,
   output logic [2:0]                state
);

   localparam int MID      = (NUM_SENS - 1) / 2;
   localparam int ERR_W    = 8;
   localparam int DUTY_MAX = (1 << DUTY_W) - 1;
   localparam int DEB_W    = $clog2(NODE_DEB + 1);
   localparam int LOST_W   = $clog2(LOST_TO + 1);
   localparam int TURN_W   = $clog2(TURN_MIN + 1);

   localparam logic [DEB_W-1:0]    DEB_LIM     = DEB_W'(NODE_DEB);
   localparam logic [LOST_W-1:0]   LOST_LIM    = LOST_W'(LOST_TO);
   localparam logic [TURN_W-1:0]   TURN_LIM    = TURN_W'(TURN_MIN);
   localparam logic [NUM_SENS-1:0] CENTRE_ONLY = NUM_SENS'(1) << MID;

   logic [NUM_SENS-1:0]     cls;
   logic signed [ERR_W-1:0] err;

   lfa_classifier #(
      .NUM_SENS (NUM_SENS),
      .ADC_W    (ADC_W),
      .TH_HI    (TH_HI),
      .TH_LO    (TH_LO),
      .ERR_W    (ERR_W)
   ) u_cls (
      .clk   (clk_3125KHz),
      .rst_n (rst_n),
      .sens  (sens),
      .cls   (cls),
      .err   (err)
   );

   logic all_black, all_white, centre_only, co_rise, turn_exit;

   state_t              state_d, state_q;
   logic [1:0]          cmd_d, cmd_q;
   logic [DEB_W-1:0]    deb_d, deb_q;
   logic [LOST_W-1:0]   lost_cnt_d, lost_cnt_q;
   logic [TURN_W-1:0]   tcnt_d, tcnt_q;
   logic [1:0]          xings_d, xings_q;
   logic [7:0]          node_cnt_d, node_cnt_q;
   logic                prev_co_d, prev_co_q;
   logic                node_pulse_d, node_pulse_q;
   logic                node_flag_d, node_flag_q;
   logic                lost_d, lost_q;
   logic [1:0]          m1_d, m1_q, m2_d, m2_q;
   logic [DUTY_W-1:0]   dc1_d, dc1_q, dc2_d, dc2_q;

   assign all_black   = &cls;
   assign all_white   = ~|cls;
   assign centre_only = (cls == CENTRE_ONLY);
   assign co_rise     = centre_only & ~prev_co_q;

   // Turn handshake: a command transfers in the cycle where turn_valid and
   // turn_ready are both high; turn_ready only rises in NODE and never while
   // stop is asserted, so the source may hold turn_valid as long as it likes.
   always_comb begin
      state_d      = state_q;
      cmd_d        = cmd_q;
      deb_d        = deb_q;
      lost_cnt_d   = lost_cnt_q;
      tcnt_d       = tcnt_q;
      xings_d      = xings_q;
      node_cnt_d   = node_cnt_q;
      prev_co_d    = centre_only;
      node_pulse_d = 1'b0;
      turn_ready   = 1'b0;
      turn_exit    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) state_d = FOLLOW;
         end
         FOLLOW: begin
            deb_d      = all_black ? ((deb_q == DEB_LIM) ? deb_q : deb_q + DEB_W'(1)) : '0;
            lost_cnt_d = all_white ? ((lost_cnt_q == LOST_LIM) ? lost_cnt_q
                                                                : lost_cnt_q + LOST_W'(1)) : '0;
            if (all_black && deb_d == DEB_LIM) begin
               state_d      = NODE;
               node_pulse_d = 1'b1;
               node_cnt_d   = node_cnt_q + 8'd1;
            end else if (all_white && lost_cnt_d == LOST_LIM) begin
               state_d = LOST;
            end
         end
         NODE: begin
            if (turn_valid) begin
               turn_ready = 1'b1;
               cmd_d      = turn_cmd;
               state_d    = TURN;
            end
         end
         TURN: begin
            if (tcnt_q != TURN_LIM) begin
               tcnt_d = tcnt_q + TURN_W'(1);
            end else begin
               case (cmd_q)
                  TC_STR: turn_exit = ~all_black;
                  TC_UTURN: begin
                     if (co_rise && xings_q != 2'd2) xings_d = xings_q + 2'd1;
                     turn_exit = co_rise && (xings_q == 2'd1);
                  end
                  default: turn_exit = centre_only;
               endcase
            end
            if (turn_exit) state_d = FOLLOW;
         end
         LOST: begin
            if (!all_white) state_d = FOLLOW;
         end
         default: state_d = IDLE;
      endcase

      if (stop) begin
         state_d      = IDLE;
         turn_ready   = 1'b0;
         node_pulse_d = 1'b0;
         node_cnt_d   = node_cnt_q;
      end

      // Debounce/lost counters live only in FOLLOW, turn counters only in TURN.
      if (state_d != FOLLOW) begin
         deb_d      = '0;
         lost_cnt_d = '0;
      end
      if (state_d != TURN) begin
         tcnt_d  = '0;
         xings_d = '0;
      end
   end

   // Outputs are registered and reflect the state being entered.
   always_comb begin
      m1_d        = OFF;
      m2_d        = OFF;
      dc1_d       = '0;
      dc2_d       = '0;
      node_flag_d = 1'b0;
      lost_d      = 1'b0;
      case (state_d)
         FOLLOW: begin
            m1_d  = FWD;
            m2_d  = FWD;
            dc1_d = DUTY_W'(sat_duty(BASE_DUTY + STEER_K * int'(err), DUTY_MAX));
            dc2_d = DUTY_W'(sat_duty(BASE_DUTY - STEER_K * int'(err), DUTY_MAX));
         end
         NODE: node_flag_d = 1'b1;
         TURN: begin
            node_flag_d = 1'b1;
            case (cmd_d)
               TC_STR: begin
                  m1_d  = FWD;
                  m2_d  = FWD;
                  dc1_d = DUTY_W'(BASE_DUTY);
                  dc2_d = DUTY_W'(BASE_DUTY);
               end
               TC_RIGHT: begin
                  m1_d  = FWD;
                  m2_d  = REV;
                  dc1_d = DUTY_W'(TURN_DUTY);
                  dc2_d = DUTY_W'(TURN_DUTY);
               end
               default: begin
                  m1_d  = REV;
                  m2_d  = FWD;
                  dc1_d = DUTY_W'(TURN_DUTY);
                  dc2_d = DUTY_W'(TURN_DUTY);
               end
            endcase
         end
         LOST: lost_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk_3125KHz) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cmd_q        <= '0;
         deb_q        <= '0;
         lost_cnt_q   <= '0;
         tcnt_q       <= '0;
         xings_q      <= '0;
         node_cnt_q   <= '0;
         prev_co_q    <= 1'b0;
         node_pulse_q <= 1'b0;
         node_flag_q  <= 1'b0;
         lost_q       <= 1'b0;
         m1_q         <= OFF;
         m2_q         <= OFF;
         dc1_q        <= '0;
         dc2_q        <= '0;
      end else begin
         state_q      <= state_d;
         cmd_q        <= cmd_d;
         deb_q        <= deb_d;
         lost_cnt_q   <= lost_cnt_d;
         tcnt_q       <= tcnt_d;
         xings_q      <= xings_d;
         node_cnt_q   <= node_cnt_d;
         prev_co_q    <= prev_co_d;
         node_pulse_q <= node_pulse_d;
         node_flag_q  <= node_flag_d;
         lost_q       <= lost_d;
         m1_q         <= m1_d;
         m2_q         <= m2_d;
         dc1_q        <= dc1_d;
         dc2_q        <= dc2_d;
      end
   end

   assign {m1_a, m1_b} = m1_q;
   assign {m2_a, m2_b} = m2_q;
   assign dc1          = dc1_q;
   assign dc2          = dc2_q;
   assign node_flag    = node_flag_q;
   assign node_pulse   = node_pulse_q;
   assign node_count   = node_cnt_q;
   assign lost         = lost_q;
   assign state        = state_q;

endmodule
